// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state, opcode and mux-select encodings for control_fsm_mc
package control_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC_EPC, S_EXC_RD, S_EXC_LOAD
  } state_t;

  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_OVF, CAUSE_OPC} cause_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] MA_PC     = 3'd0;
  localparam logic [2:0] MA_ALUOUT = 3'd1;
  localparam logic [2:0] MA_EXC    = 3'd5;

  localparam logic [1:0] UA_PC = 2'd0;
  localparam logic [1:0] UA_A  = 2'd2;

  localparam logic [2:0] UB_B        = 3'd0;
  localparam logic [2:0] UB_FOUR     = 3'd2;
  localparam logic [2:0] UB_SEXT     = 3'd3;
  localparam logic [2:0] UB_SEXT_SH2 = 3'd4;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  localparam logic [2:0] PC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_ALU    = 3'd5;
  localparam logic [2:0] PC_MEM    = 3'd6;

  localparam logic [1:0] WR_RD = 2'd0;
  localparam logic [1:0] WR_RT = 2'd1;

  localparam logic [2:0] WD_ALUOUT = 3'd0;
  localparam logic [2:0] WD_MDR    = 3'd1;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_EXC_RD);
  endfunction

endpackage

// File: rtl/control_fsm_mc.sv
// rtl/control_fsm_mc.sv - multicycle MIPS-subset control unit with memory waits and exceptions
module control_fsm_mc
  import control_pkg::*;
#(
  parameter int         MEM_WAIT = 1,
  parameter logic [7:0] OVF_VEC  = 8'd254,
  parameter logic [7:0] OPC_VEC  = 8'd253
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       O,
  input  logic       ZERO,
  output logic       PCwrite,
  output logic       IRwrite,
  output logic       RegWrite,
  output logic       wr,
  output logic       ALUOUT,
  output logic       EPC,
  output logic [2:0] MemoryAdress,
  output logic [1:0] ULAa,
  output logic [2:0] ULAb,
  output logic [2:0] ULAcontrol,
  output logic [2:0] PCmux,
  output logic [1:0] WriteReg,
  output logic [2:0] WriteData,
  output logic [7:0] exc_vec,
  output logic [4:0] state_dbg
);

  localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_INIT = CW'(MEM_WAIT - 1);

  state_t        state;
  cause_t        cause;
  logic [CW-1:0] cnt;
  logic          released;
  logic          wait_done;
  logic          r_ovf_capable;

  assign wait_done     = (cnt == '0);
  assign r_ovf_capable = (funct == FN_ADD) || (funct == FN_SUB);
  assign state_dbg     = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      cause    <= CAUSE_NONE;
      cnt      <= '0;
      released <= 1'b0;
    end else begin
      // counter sits at WAIT_INIT outside wait states, so every wait state entry sees a fresh count
      if (is_wait_state(state) && !wait_done) cnt <= cnt - CW'(1);
      else cnt <= WAIT_INIT;

      case (state)
        S_RESET: begin
          if (released) state <= S_FETCH;
          else released <= 1'b1;
        end
        S_FETCH: if (wait_done) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) state <= S_EXEC_R;
              else begin
                state <= S_EXC_EPC;
                cause <= CAUSE_OPC;
              end
            end
            OP_ADDI:      state <= S_EXEC_I;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
              state <= S_EXC_EPC;
              cause <= CAUSE_OPC;
            end
          endcase
        end
        S_EXEC_R: state <= S_WB_R;
        S_EXEC_I: state <= S_WB_I;
        S_WB_R: begin
          if (O && r_ovf_capable) begin
            state <= S_EXC_EPC;
            cause <= CAUSE_OVF;
          end else state <= S_FETCH;
        end
        S_WB_I: begin
          if (O) begin
            state <= S_EXC_EPC;
            cause <= CAUSE_OVF;
          end else state <= S_FETCH;
        end
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (wait_done) state <= S_MEM_WB;
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_EXC_LOAD: state <= S_FETCH;
        S_EXC_EPC:  state <= S_EXC_RD;
        S_EXC_RD:   if (wait_done) state <= S_EXC_LOAD;
        default:    state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    PCwrite      = 1'b0;
    IRwrite      = 1'b0;
    RegWrite     = 1'b0;
    wr           = 1'b0;
    ALUOUT       = 1'b0;
    EPC          = 1'b0;
    MemoryAdress = MA_PC;
    ULAa         = UA_PC;
    ULAb         = UB_B;
    ULAcontrol   = ALU_PASS;
    PCmux        = '0;
    WriteReg     = WR_RD;
    WriteData    = WD_ALUOUT;
    case (state)
      S_FETCH: begin
        ULAb       = UB_FOUR;
        ULAcontrol = ALU_ADD;
        if (wait_done) begin
          IRwrite = 1'b1;
          PCwrite = 1'b1;
          PCmux   = PC_ALU;
        end
      end
      S_DECODE: begin
        ULAb       = UB_SEXT_SH2;
        ULAcontrol = ALU_ADD;
        ALUOUT     = 1'b1;
      end
      S_EXEC_R: begin
        ULAa   = UA_A;
        ALUOUT = 1'b1;
        case (funct)
          FN_SUB:  ULAcontrol = ALU_SUB;
          FN_AND:  ULAcontrol = ALU_AND;
          default: ULAcontrol = ALU_ADD;
        endcase
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ULAa       = UA_A;
        ULAb       = UB_SEXT;
        ULAcontrol = ALU_ADD;
        ALUOUT     = 1'b1;
      end
      S_WB_R: RegWrite = !(O && r_ovf_capable);
      S_WB_I: begin
        RegWrite = !O;
        WriteReg = WR_RT;
      end
      S_MEM_RD: MemoryAdress = MA_ALUOUT;
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        WriteData = WD_MDR;
        WriteReg  = WR_RT;
      end
      S_MEM_WR: begin
        MemoryAdress = MA_ALUOUT;
        wr           = 1'b1;
      end
      S_BRANCH: begin
        ULAa       = UA_A;
        ULAcontrol = ALU_SUB;
        PCmux      = PC_ALUOUT;
        PCwrite    = ZERO;
      end
      S_JUMP: begin
        PCmux   = PC_JUMP;
        PCwrite = 1'b1;
      end
      S_EXC_EPC: begin
        ULAb       = UB_FOUR;
        ULAcontrol = ALU_SUB;
        EPC        = 1'b1;
      end
      S_EXC_RD: MemoryAdress = MA_EXC;
      S_EXC_LOAD: begin
        PCmux   = PC_MEM;
        PCwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    exc_vec = 8'd0;
    case (cause)
      CAUSE_OVF: exc_vec = OVF_VEC;
      CAUSE_OPC: exc_vec = OPC_VEC;
      default:   exc_vec = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_control_fsm_mc.sv
// tb/tb_control_fsm_mc.sv - directed bench for control_fsm_mc at MEM_WAIT=1 and MEM_WAIT=3
module tb_control_fsm_mc;
  import control_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       O = 1'b0;
  logic       ZERO = 1'b0;

  logic       a_PCwrite, a_IRwrite, a_RegWrite, a_wr, a_ALUOUT, a_EPC;
  logic [2:0] a_MemoryAdress, a_ULAb, a_ULAcontrol, a_PCmux, a_WriteData;
  logic [1:0] a_ULAa, a_WriteReg;
  logic [7:0] a_exc_vec;
  logic [4:0] a_state;

  logic       b_PCwrite, b_IRwrite, b_RegWrite, b_wr, b_ALUOUT, b_EPC;
  logic [2:0] b_MemoryAdress, b_ULAb, b_ULAcontrol, b_PCmux, b_WriteData;
  logic [1:0] b_ULAa, b_WriteReg;
  logic [7:0] b_exc_vec;
  logic [4:0] b_state;

  logic [38:0] b_all;
  assign b_all = {b_PCwrite, b_IRwrite, b_RegWrite, b_wr, b_ALUOUT, b_EPC, b_MemoryAdress,
                  b_ULAa, b_ULAb, b_ULAcontrol, b_PCmux, b_WriteReg, b_WriteData, b_exc_vec,
                  b_state};

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  control_fsm_mc #(.MEM_WAIT(1)) u_w1 (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .O(O), .ZERO(ZERO),
    .PCwrite(a_PCwrite), .IRwrite(a_IRwrite), .RegWrite(a_RegWrite), .wr(a_wr),
    .ALUOUT(a_ALUOUT), .EPC(a_EPC), .MemoryAdress(a_MemoryAdress), .ULAa(a_ULAa),
    .ULAb(a_ULAb), .ULAcontrol(a_ULAcontrol), .PCmux(a_PCmux), .WriteReg(a_WriteReg),
    .WriteData(a_WriteData), .exc_vec(a_exc_vec), .state_dbg(a_state)
  );

  control_fsm_mc #(.MEM_WAIT(3)) u_w3 (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .O(O), .ZERO(ZERO),
    .PCwrite(b_PCwrite), .IRwrite(b_IRwrite), .RegWrite(b_RegWrite), .wr(b_wr),
    .ALUOUT(b_ALUOUT), .EPC(b_EPC), .MemoryAdress(b_MemoryAdress), .ULAa(b_ULAa),
    .ULAb(b_ULAb), .ULAcontrol(b_ULAcontrol), .PCmux(b_PCmux), .WriteReg(b_WriteReg),
    .WriteData(b_WriteData), .exc_vec(b_exc_vec), .state_dbg(b_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // leaves both instances in cycle 1 of their first FETCH
  task automatic go_fetch(input logic [5:0] op, input logic [5:0] fn, input logic o, input logic z);
    reset = 1'b1;
    opcode = op;
    funct = fn;
    O = o;
    ZERO = z;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("rel_edge1_w1", 64'(a_state), 64'(S_RESET));
    chk("rel_edge1_w3", 64'(b_state), 64'(S_RESET));
    step();
    chk("rel_edge2_w1", 64'(a_state), 64'(S_FETCH));
    chk("rel_edge2_w3", 64'(b_state), 64'(S_FETCH));
  endtask

  initial begin
    int pcw;
    int ma1;
    int irw;

    @(negedge clock);
    chk("reset_state", 64'(b_state), 64'(S_RESET));
    chk("reset_outs", 64'(b_all), 64'(0));

    // add, MEM_WAIT=1
    go_fetch(6'h00, 6'h20, 1'b0, 1'b0);
    pcw = 0;
    for (int c = 1; c <= 4; c++) begin
      pcw += int'(a_PCwrite);
      if (c == 1) begin
        chk("add_fetch_pcw", 64'(a_PCwrite), 64'(1));
        chk("add_fetch_irw", 64'(a_IRwrite), 64'(1));
        chk("add_fetch_pcmux", 64'(a_PCmux), 64'(5));
        chk("add_fetch_ulab", 64'(a_ULAb), 64'(2));
      end
      if (c == 2) begin
        chk("add_dec_state", 64'(a_state), 64'(S_DECODE));
        chk("add_dec_aluout", 64'(a_ALUOUT), 64'(1));
        chk("add_dec_ulab", 64'(a_ULAb), 64'(4));
      end
      if (c == 3) begin
        chk("add_ex_ulaa", 64'(a_ULAa), 64'(2));
        chk("add_ex_ctl", 64'(a_ULAcontrol), 64'(1));
      end
      if (c == 4) begin
        chk("add_wb_regw", 64'(a_RegWrite), 64'(1));
        chk("add_wb_wreg", 64'(a_WriteReg), 64'(0));
        chk("add_wb_wdata", 64'(a_WriteData), 64'(0));
      end
      step();
    end
    chk("add_pcw_pulses", 64'(pcw), 64'(1));
    chk("add_next_fetch", 64'(a_state), 64'(S_FETCH));

    // lw, MEM_WAIT=3
    go_fetch(6'h23, 6'h00, 1'b0, 1'b0);
    ma1 = 0;
    irw = 0;
    for (int c = 1; c <= 9; c++) begin
      ma1 += int'(b_MemoryAdress == 3'd1);
      irw += int'(b_IRwrite);
      if (c == 3) chk("lw_irw_last", 64'(b_IRwrite), 64'(1));
      if (c == 9) begin
        chk("lw_wb_regw", 64'(b_RegWrite), 64'(1));
        chk("lw_wb_wdata", 64'(b_WriteData), 64'(1));
        chk("lw_wb_wreg", 64'(b_WriteReg), 64'(1));
      end
      step();
    end
    chk("lw_ma1_cycles", 64'(ma1), 64'(3));
    chk("lw_irw_cycles", 64'(irw), 64'(1));
    chk("lw_next_fetch", 64'(b_state), 64'(S_FETCH));

    // sub with overflow on both widths
    go_fetch(6'h00, 6'h22, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      if (c == 3) chk("sub_ex_ctl", 64'(a_ULAcontrol), 64'(2));
      if (c == 4) chk("sub_wb_regw", 64'(a_RegWrite), 64'(0));
      if (c == 5) begin
        chk("sub_epc", 64'(a_EPC), 64'(1));
        chk("sub_epc_ctl", 64'(a_ULAcontrol), 64'(2));
      end
      if (c == 6) begin
        chk("sub_rd_ma", 64'(a_MemoryAdress), 64'(5));
        chk("sub_vec", 64'(a_exc_vec), 64'(254));
      end
      if (c == 7) begin
        chk("sub_load_pcmux", 64'(a_PCmux), 64'(6));
        chk("sub_load_pcw", 64'(a_PCwrite), 64'(1));
      end
      if (c == 8) begin
        chk("sub_refetch", 64'(a_state), 64'(S_FETCH));
        chk("sub_vec_hold", 64'(a_exc_vec), 64'(254));
      end
      if (c == 6) chk("sub_w3_regw", 64'(b_RegWrite), 64'(0));
      if (c == 7) chk("sub_w3_epc", 64'(b_EPC), 64'(1));
      if (c == 10) chk("sub_w3_rd_last", 64'(b_MemoryAdress), 64'(5));
      if (c == 11) chk("sub_w3_load", 64'(b_PCwrite), 64'(1));
      step();
    end

    // and ignores O; addi honours it
    go_fetch(6'h00, 6'h24, 1'b1, 1'b0);
    step(); step();
    chk("and_ctl", 64'(a_ULAcontrol), 64'(3));
    step();
    chk("and_ovf_ignored", 64'(a_RegWrite), 64'(1));
    step();
    chk("and_refetch", 64'(a_state), 64'(S_FETCH));

    go_fetch(6'h08, 6'h00, 1'b1, 1'b0);
    step(); step();
    chk("addi_ulab", 64'(a_ULAb), 64'(3));
    step();
    chk("addi_wb_regw", 64'(a_RegWrite), 64'(0));
    step();
    chk("addi_epc", 64'(a_state), 64'(S_EXC_EPC));
    chk("addi_vec", 64'(a_exc_vec), 64'(254));

    // unknown opcode and unknown R-type funct
    go_fetch(6'h3f, 6'h00, 1'b0, 1'b0);
    step(); step();
    chk("opc_epc_state", 64'(a_state), 64'(S_EXC_EPC));
    chk("opc_vec", 64'(a_exc_vec), 64'(253));
    chk("opc_epc_we", 64'(a_EPC), 64'(1));

    go_fetch(6'h00, 6'h25, 1'b0, 1'b0);
    step(); step();
    chk("fn_unknown_epc", 64'(a_state), 64'(S_EXC_EPC));

    // beq not taken / taken, j, sw
    go_fetch(6'h04, 6'h00, 1'b0, 1'b0);
    step(); step();
    chk("beq_nt_state", 64'(a_state), 64'(S_BRANCH));
    chk("beq_nt_pcw", 64'(a_PCwrite), 64'(0));
    step();
    chk("beq_nt_refetch", 64'(a_state), 64'(S_FETCH));

    go_fetch(6'h04, 6'h00, 1'b0, 1'b1);
    step();
    chk("beq_dec_pcw", 64'(a_PCwrite), 64'(0));
    step();
    chk("beq_t_pcw", 64'(a_PCwrite), 64'(1));
    chk("beq_t_pcmux", 64'(a_PCmux), 64'(1));
    chk("beq_t_ctl", 64'(a_ULAcontrol), 64'(2));

    go_fetch(6'h02, 6'h00, 1'b0, 1'b0);
    step(); step();
    chk("j_pcmux", 64'(a_PCmux), 64'(2));
    chk("j_pcw", 64'(a_PCwrite), 64'(1));
    step();
    chk("j_refetch", 64'(a_state), 64'(S_FETCH));

    go_fetch(6'h2b, 6'h00, 1'b0, 1'b0);
    step(); step(); step();
    chk("sw_wr", 64'(a_wr), 64'(1));
    chk("sw_ma", 64'(a_MemoryAdress), 64'(1));
    step();
    chk("sw_refetch", 64'(a_state), 64'(S_FETCH));

    // asynchronous reset in MEM_RD (MEM_WAIT=3, cycle 7 is the second read cycle)
    go_fetch(6'h23, 6'h00, 1'b0, 1'b0);
    repeat (6) step();
    chk("lw_mid_rd", 64'(b_state), 64'(S_MEM_RD));
    #2 reset = 1'b1;
    #1 chk("rst_async_outs", 64'(b_all), 64'(0));

    // cause cleared by reset while in the exception vector read
    go_fetch(6'h3f, 6'h00, 1'b0, 1'b0);
    repeat (5) step();
    chk("opc_w3_rd_vec", 64'(b_exc_vec), 64'(253));
    #2 reset = 1'b1;
    #1 chk("rst_cause_clr", 64'(b_exc_vec), 64'(0));
    chk("rst_state", 64'(b_state), 64'(S_RESET));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
